// File: rtl/jtag_driver.sv
// JTAG master: turns reset / IR-shift / DR-shift / run-idle commands into TCK/TMS/TDI
// bit sequences that start and end in Run-Test/Idle, and returns the TDO bits captured while shifting.
module jtag_driver #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned CLK_DIV = 2,
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic               tck,
  input  logic               trst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               jtck_o,
  output logic               jtms_o,
  output logic               jtdi_o,
  output logic               jtrst_o,
  input  logic               jtdo_i
);

  localparam int unsigned BIT_W = $clog2(MAX_LEN + 7);
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_LOW, S_HIGH, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [LEN_W-1:0]   sidx_q, sidx_d;
  logic [1:0]         op_q, op_d;
  logic [BIT_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic               init_q, init_d;
  logic               jtck_q, jtck_d, jtms_q, jtms_d, jtdi_q, jtdi_d, jtrst_q, jtrst_d;
  logic               ready_q, ready_d, rsp_valid_q, rsp_valid_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;

  logic               accept, div_end, last_bit, cur_shift, nxt_shift;
  logic [BIT_W-1:0]   cmd_l, total, nxt_bit;
  logic [MAX_LEN-1:0] data_n;

  // Bits in a command: fixed TMS walk around the L shift bits.
  function automatic logic [BIT_W-1:0] total_of(input logic [1:0] op, input logic [BIT_W-1:0] l);
    case (op)
      OP_RESET: total_of = BIT_W'(6);
      OP_IR:    total_of = l + BIT_W'(6);
      OP_DR:    total_of = l + BIT_W'(5);
      default:  total_of = l;
    endcase
  endfunction

  function automatic logic shift_of(input logic [1:0] op, input logic [BIT_W-1:0] l,
                                    input logic [BIT_W-1:0] b);
    case (op)
      OP_IR:   shift_of = (b >= BIT_W'(4)) && (b < l + BIT_W'(4));
      OP_DR:   shift_of = (b >= BIT_W'(3)) && (b < l + BIT_W'(3));
      default: shift_of = 1'b0;
    endcase
  endfunction

  function automatic logic tms_of(input logic [1:0] op, input logic [BIT_W-1:0] l,
                                  input logic [BIT_W-1:0] b);
    case (op)
      OP_RESET: tms_of = (b < BIT_W'(5));
      OP_IR:    tms_of = (b < BIT_W'(2)) || (b == l + BIT_W'(3)) || (b == l + BIT_W'(4));
      OP_DR:    tms_of = (b == '0) || (b == l + BIT_W'(2)) || (b == l + BIT_W'(3));
      default:  tms_of = 1'b0;
    endcase
  endfunction

  always_comb begin
    if (cmd_len == '0)                    cmd_l = BIT_W'(1);
    else if (cmd_len > LEN_W'(MAX_LEN))   cmd_l = BIT_W'(MAX_LEN);
    else                                  cmd_l = BIT_W'(cmd_len);
  end

  assign accept    = cmd_valid & ready_q;
  assign div_end   = (div_q == DIV_W'(CLK_DIV - 1));
  assign total     = total_of(op_q, len_q);
  assign last_bit  = (bit_q == total - BIT_W'(1));
  assign cur_shift = shift_of(op_q, len_q, bit_q);
  assign nxt_bit   = bit_q + BIT_W'(1);
  assign nxt_shift = shift_of(op_q, len_q, nxt_bit);
  assign data_n    = cur_shift ? (data_q >> 1) : data_q;

  always_ff @(posedge tck) begin
    if (!trst) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:         state_d = S_LOW;
      S_IDLE, S_DONE: state_d = accept ? S_LOW : S_IDLE;
      S_LOW:          if (div_end) state_d = S_HIGH;
      S_HIGH:         if (div_end) state_d = !last_bit ? S_LOW : (init_q ? S_IDLE : S_DONE);
      default:        state_d = S_INIT;
    endcase
  end

  // Pin and datapath updates; TMS/TDI change only where jtck falls, TDO sampled where it rises.
  always_comb begin
    div_d       = div_q;
    bit_d       = bit_q;
    sidx_d      = sidx_q;
    op_d        = op_q;
    len_d       = len_q;
    data_d      = data_q;
    cap_d       = cap_q;
    init_d      = init_q;
    jtck_d      = jtck_q;
    jtms_d      = jtms_q;
    jtdi_d      = jtdi_q;
    jtrst_d     = jtrst_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_INIT: begin
        jtrst_d = 1'b1;
        init_d  = 1'b1;
        op_d    = OP_RESET;
        bit_d   = '0;
        div_d   = '0;
        jtck_d  = 1'b0;
        jtms_d  = 1'b1;
        jtdi_d  = 1'b0;
      end
      S_IDLE, S_DONE: begin
        if (accept) begin
          op_d    = cmd_op;
          len_d   = cmd_l;
          data_d  = cmd_data;
          cap_d   = '0;
          bit_d   = '0;
          sidx_d  = '0;
          div_d   = '0;
          init_d  = 1'b0;
          ready_d = 1'b0;
          jtms_d  = tms_of(cmd_op, cmd_l, '0);
          jtdi_d  = 1'b0;
        end
      end
      S_LOW: begin
        if (div_end) begin
          div_d  = '0;
          jtck_d = 1'b1;
          if (cur_shift) cap_d = cap_q | (MAX_LEN'(jtdo_i) << sidx_q);
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_HIGH: begin
        if (div_end) begin
          div_d  = '0;
          jtck_d = 1'b0;
          if (last_bit) begin
            jtms_d  = 1'b1;
            jtdi_d  = 1'b0;
            ready_d = 1'b1;
            if (!init_q) begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = cap_q;
            end
          end else begin
            bit_d  = nxt_bit;
            data_d = data_n;
            if (cur_shift) sidx_d = sidx_q + LEN_W'(1);
            jtms_d = tms_of(op_q, len_q, nxt_bit);
            jtdi_d = nxt_shift & data_n[0];
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge tck) begin
    if (!trst) begin
      div_q       <= '0;
      bit_q       <= '0;
      sidx_q      <= '0;
      op_q        <= OP_RESET;
      len_q       <= '0;
      data_q      <= '0;
      cap_q       <= '0;
      init_q      <= 1'b1;
      jtck_q      <= 1'b0;
      jtms_q      <= 1'b1;
      jtdi_q      <= 1'b0;
      jtrst_q     <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      div_q       <= div_d;
      bit_q       <= bit_d;
      sidx_q      <= sidx_d;
      op_q        <= op_d;
      len_q       <= len_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      init_q      <= init_d;
      jtck_q      <= jtck_d;
      jtms_q      <= jtms_d;
      jtdi_q      <= jtdi_d;
      jtrst_q     <= jtrst_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = ~ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign jtck_o    = jtck_q;
  assign jtms_o    = jtms_q;
  assign jtdi_o    = jtdi_q;
  assign jtrst_o   = jtrst_q;

endmodule

// File: tb/tb_jtag_driver.sv
// Directed bench for jtag_driver: a behavioural TAP (4-bit IR capturing 0101, 32-bit DR)
// answers on TDO while each scenario task checks latency, pin sequences and returned data.
module tb_jtag_driver;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;
  localparam logic [1:0] OP_IDLE  = 2'b11;

  logic        tck = 1'b0;
  logic        trst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [5:0]  cmd_len = 6'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy;
  logic        jtck_o, jtms_o, jtdi_o, jtrst_o;
  logic        tap_tdo = 1'b0;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  jtag_driver dut (
    .tck(tck), .trst(trst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .jtck_o(jtck_o), .jtms_o(jtms_o), .jtdi_o(jtdi_o), .jtrst_o(jtrst_o),
    .jtdo_i(tap_tdo)
  );

  always #5 tck = ~tck;

  // Target TAP controller
  typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDR,
                            SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPIR} tap_e;
  tap_e        tap_st = TLR;
  logic [31:0] tap_dr = 32'h12345678;
  logic [31:0] tap_dr_sr = 32'd0;
  logic [3:0]  tap_ir = 4'd0;
  logic [3:0]  tap_ir_sr = 4'd0;

  always @(posedge jtck_o or negedge jtrst_o) begin
    if (!jtrst_o) begin
      tap_st <= TLR;
    end else begin
      case (tap_st)
        CAPDR: tap_dr_sr <= tap_dr;
        SHDR:  tap_dr_sr <= {jtdi_o, tap_dr_sr[31:1]};
        UPDR:  tap_dr    <= tap_dr_sr;
        CAPIR: tap_ir_sr <= 4'b0101;
        SHIR:  tap_ir_sr <= {jtdi_o, tap_ir_sr[3:1]};
        UPIR:  tap_ir    <= tap_ir_sr;
        default: ;
      endcase
      case (tap_st)
        TLR:   tap_st <= jtms_o ? TLR   : RTI;
        RTI:   tap_st <= jtms_o ? SELDR : RTI;
        SELDR: tap_st <= jtms_o ? SELIR : CAPDR;
        CAPDR: tap_st <= jtms_o ? EX1DR : SHDR;
        SHDR:  tap_st <= jtms_o ? EX1DR : SHDR;
        EX1DR: tap_st <= jtms_o ? UPDR  : PAUDR;
        PAUDR: tap_st <= jtms_o ? EX2DR : PAUDR;
        EX2DR: tap_st <= jtms_o ? UPDR  : SHDR;
        UPDR:  tap_st <= jtms_o ? SELDR : RTI;
        SELIR: tap_st <= jtms_o ? TLR   : CAPIR;
        CAPIR: tap_st <= jtms_o ? EX1IR : SHIR;
        SHIR:  tap_st <= jtms_o ? EX1IR : SHIR;
        EX1IR: tap_st <= jtms_o ? UPIR  : PAUIR;
        PAUIR: tap_st <= jtms_o ? EX2IR : PAUIR;
        EX2IR: tap_st <= jtms_o ? UPIR  : SHIR;
        default: tap_st <= jtms_o ? SELDR : RTI;
      endcase
    end
  end

  always @(negedge jtck_o)
    tap_tdo <= (tap_st == SHDR) ? tap_dr_sr[0] : (tap_st == SHIR) ? tap_ir_sr[0] : 1'b0;

  logic tms_hist[$];
  logic tdi_hist[$];
  always @(posedge jtck_o) begin
    tms_hist.push_back(jtms_o);
    tdi_hist.push_back(jtdi_o);
  end

  function automatic logic [63:0] tms_from(input int s);
    logic [63:0] r = '0;
    for (int i = s; i < tms_hist.size() && i - s < 64; i++) r[i-s] = tms_hist[i];
    return r;
  endfunction

  function automatic logic [63:0] tdi_from(input int s);
    logic [63:0] r = '0;
    for (int i = s; i < tdi_hist.size() && i - s < 64; i++) r[i-s] = tdi_hist[i];
    return r;
  endfunction

  // Release trst; lat = cycle (first trst=1 edge counted as 1) at which cmd_ready is seen.
  task automatic run_init(output int lat, output logic rst_first, output int nrsp);
    trst = 1'b1; lat = -1; nrsp = 0; rst_first = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge tck); #1;
      if (k == 1) rst_first = jtrst_o;
      if (rsp_valid) nrsp++;
      if (cmd_ready) begin lat = k; break; end
    end
  endtask

  // Issue one command (caller guarantees cmd_ready); returns in the rsp_valid cycle.
  task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                         input bit noise, output int lat, output int first);
    first = tms_hist.size();
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
    @(posedge tck); #1;
    cmd_valid = 1'b0; cmd_op = ~op; cmd_len = 6'($urandom); cmd_data = $urandom;
    lat = -1;
    for (int k = 1; k <= 4000; k++) begin
      cmd_valid = noise && (k >= 10) && (k <= 12);
      if (cmd_valid) begin cmd_op = OP_IR; cmd_len = 6'd4; end
      @(posedge tck); #1;
      if (rsp_valid) begin lat = k + 1; break; end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    int lat, nrsp, first;
    logic rst_first;
    repeat (3) @(posedge tck);
    #1;
    vec_cnt++; if ({jtck_o, jtms_o, jtdi_o, jtrst_o} !== 4'b0100) begin miss_cnt++;
      $display("FAIL reset_pins got %b expected 0100", {jtck_o, jtms_o, jtdi_o, jtrst_o}); end
    vec_cnt++; if ({cmd_ready, busy, rsp_valid} !== 3'b010 || rsp_data !== 32'd0) begin miss_cnt++;
      $display("FAIL reset_ctrl got rdy/busy/vld=%b data=%h expected 010 data=0", {cmd_ready, busy, rsp_valid}, rsp_data); end
    first = tms_hist.size();
    run_init(lat, rst_first, nrsp);
    vec_cnt++; if (rst_first !== 1'b1) begin miss_cnt++; $display("FAIL init_jtrst got %b expected 1", rst_first); end
    vec_cnt++; if (lat !== 25) begin miss_cnt++; $display("FAIL init_ready_cycle got %0d expected 25", lat); end
    vec_cnt++; if (tms_hist.size() - first !== 6) begin miss_cnt++;
      $display("FAIL init_pulses got %0d expected 6", tms_hist.size() - first); end
    vec_cnt++; if (tms_from(first) !== 64'h1F) begin miss_cnt++; $display("FAIL init_tms got %h expected 1f", tms_from(first)); end
    vec_cnt++; if (nrsp !== 0) begin miss_cnt++; $display("FAIL init_rsp got %0d expected 0", nrsp); end
    repeat (3) @(posedge tck);
    #1;
    vec_cnt++; if ({jtck_o, jtms_o, busy, cmd_ready} !== 4'b0101) begin miss_cnt++;
      $display("FAIL idle_pins got %b expected 0101", {jtck_o, jtms_o, busy, cmd_ready}); end
  endtask

  task automatic test_ir();
    int lat, first;
    run_cmd(OP_IR, 6'd4, 32'hA, 1'b0, lat, first);
    vec_cnt++; if (lat !== 41) begin miss_cnt++; $display("FAIL ir_latency got %0d expected 41", lat); end
    vec_cnt++; if (rsp_data !== 32'h5) begin miss_cnt++; $display("FAIL ir_rsp got %h expected 5", rsp_data); end
    vec_cnt++; if (tms_hist.size() - first !== 10) begin miss_cnt++;
      $display("FAIL ir_pulses got %0d expected 10", tms_hist.size() - first); end
    vec_cnt++; if (tms_from(first) !== 64'h183) begin miss_cnt++; $display("FAIL ir_tms got %h expected 183", tms_from(first)); end
    vec_cnt++; if (tdi_from(first) !== 64'hA0) begin miss_cnt++; $display("FAIL ir_tdi got %h expected a0", tdi_from(first)); end
    vec_cnt++; if (tap_ir !== 4'hA) begin miss_cnt++; $display("FAIL ir_update got %h expected a", tap_ir); end
    vec_cnt++; if ({cmd_ready, jtck_o} !== 2'b10) begin miss_cnt++;
      $display("FAIL ir_done_ctrl got %b expected 10", {cmd_ready, jtck_o}); end
    @(posedge tck); #1;
    vec_cnt++; if (rsp_valid !== 1'b0 || rsp_data !== 32'h5) begin miss_cnt++;
      $display("FAIL ir_rsp_hold got vld=%b data=%h expected vld=0 data=5", rsp_valid, rsp_data); end
  endtask

  task automatic test_dr();
    int lat, first;
    run_cmd(OP_DR, 6'd32, 32'hDEADBEEF, 1'b0, lat, first);
    vec_cnt++; if (lat !== 149) begin miss_cnt++; $display("FAIL dr_latency got %0d expected 149", lat); end
    vec_cnt++; if (rsp_data !== 32'h12345678) begin miss_cnt++; $display("FAIL dr_rsp got %h expected 12345678", rsp_data); end
    vec_cnt++; if (tms_hist.size() - first !== 37) begin miss_cnt++;
      $display("FAIL dr_pulses got %0d expected 37", tms_hist.size() - first); end
    vec_cnt++; if (tms_from(first) !== 64'hC_0000_0001) begin miss_cnt++;
      $display("FAIL dr_tms got %h expected c00000001", tms_from(first)); end
    vec_cnt++; if (tdi_from(first) !== 64'h6_F56D_F778) begin miss_cnt++;
      $display("FAIL dr_tdi got %h expected 6f56df778", tdi_from(first)); end
    vec_cnt++; if (tap_dr !== 32'hDEADBEEF) begin miss_cnt++; $display("FAIL dr_update got %h expected deadbeef", tap_dr); end
  endtask

  task automatic test_back_to_back();
    int lat, first;
    run_cmd(OP_IDLE, 6'd3, 32'hFFFF_FFFF, 1'b0, lat, first);
    vec_cnt++; if (lat !== 13 || tms_hist.size() - first !== 3) begin miss_cnt++;
      $display("FAIL idle3 got lat=%0d pulses=%0d expected lat=13 pulses=3", lat, tms_hist.size() - first); end
    vec_cnt++; if (tms_from(first) !== 64'h0 || tdi_from(first) !== 64'h0 || rsp_data !== 32'h0) begin miss_cnt++;
      $display("FAIL idle3_bits got tms=%h tdi=%h rsp=%h expected 0 0 0", tms_from(first), tdi_from(first), rsp_data); end
    run_cmd(OP_IDLE, 6'd0, 32'hFFFF_FFFF, 1'b0, lat, first);
    vec_cnt++; if (lat !== 5 || tms_hist.size() - first !== 1) begin miss_cnt++;
      $display("FAIL idle0 got lat=%0d pulses=%0d expected lat=5 pulses=1", lat, tms_hist.size() - first); end
    vec_cnt++; if (tms_from(first) !== 64'h0 || rsp_data !== 32'h0) begin miss_cnt++;
      $display("FAIL idle0_bits got tms=%h rsp=%h expected 0 0", tms_from(first), rsp_data); end
  endtask

  task automatic test_clamp_busy();
    int lat, first, extra;
    run_cmd(OP_DR, 6'd40, 32'h0F0F_1234, 1'b1, lat, first);
    vec_cnt++; if (lat !== 149 || tms_hist.size() - first !== 37) begin miss_cnt++;
      $display("FAIL clamp got lat=%0d pulses=%0d expected lat=149 pulses=37", lat, tms_hist.size() - first); end
    vec_cnt++; if (rsp_data !== 32'hDEADBEEF || tap_dr !== 32'h0F0F_1234) begin miss_cnt++;
      $display("FAIL clamp_data got rsp=%h dr=%h expected deadbeef 0f0f1234", rsp_data, tap_dr); end
    extra = 0;
    repeat (20) begin @(posedge tck); #1; if (rsp_valid) extra++; end
    vec_cnt++; if (extra !== 0 || cmd_ready !== 1'b1) begin miss_cnt++;
      $display("FAIL busy_ignore got extra_rsp=%0d rdy=%b expected 0 1", extra, cmd_ready); end
  endtask

  task automatic test_mid_reset();
    int lat, nrsp, first;
    logic rst_first;
    cmd_valid = 1'b1; cmd_op = OP_DR; cmd_len = 6'd32; cmd_data = 32'h55AA_55AA;
    @(posedge tck); #1;
    cmd_valid = 1'b0;
    nrsp = 0;
    repeat (30) begin @(posedge tck); #1; if (rsp_valid) nrsp++; end
    trst = 1'b0;
    @(posedge tck); #1;
    vec_cnt++; if ({jtck_o, jtms_o, jtdi_o, jtrst_o, cmd_ready, rsp_valid} !== 6'b010000 || rsp_data !== 32'd0) begin
      miss_cnt++; $display("FAIL midrst_pins got %b data=%h expected 010000 data=0",
                           {jtck_o, jtms_o, jtdi_o, jtrst_o, cmd_ready, rsp_valid}, rsp_data); end
    repeat (3) begin @(posedge tck); #1; if (rsp_valid) nrsp++; end
    first = tms_hist.size();
    run_init(lat, rst_first, nrsp);
    vec_cnt++; if (lat !== 25 || nrsp !== 0 || rst_first !== 1'b1) begin miss_cnt++;
      $display("FAIL midrst_init got lat=%0d rsp=%0d jtrst=%b expected 25 0 1", lat, nrsp, rst_first); end
    vec_cnt++; if (tms_from(first) !== 64'h1F || tms_hist.size() - first !== 6) begin miss_cnt++;
      $display("FAIL midrst_tms got %h pulses=%0d expected 1f 6", tms_from(first), tms_hist.size() - first); end
    run_cmd(OP_IR, 6'd4, 32'h3, 1'b0, lat, first);
    vec_cnt++; if (lat !== 41 || rsp_data !== 32'h5) begin miss_cnt++;
      $display("FAIL midrst_ir got lat=%0d rsp=%h expected 41 5", lat, rsp_data); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ir();
    test_dr();
    test_back_to_back();
    test_clamp_busy();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/jtag_driver.md
# jtag_driver

JTAG master that drives a target TAP (scan-chain TAP wrapper on the DUT side) from a single system clock. It accepts IR-shift, DR-shift, TAP-reset and run-idle commands over a valid/ready interface, produces TCK/TMS/TDI/TRST, and returns the TDO bits captured during each shift. Used by on-chip test controllers and simulation benches to load scan chains through the TAP.

## Interface
- `MAX_LEN`, 32: maximum bits per shift, 1..64; `LEN_W = $clog2(MAX_LEN+1)`.
- `CLK_DIV`, 2: `tck` cycles per JTAG clock phase (≥1); one JTAG bit = 2·CLK_DIV cycles.

Ports:
- `tck`  in  1  system clock; all logic on its rising edge.
- `trst`  in  1  reset; synchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  driver idle; command accepted when `cmd_valid & cmd_ready`.
- `cmd_op`  in  2  00 TAP reset, 01 shift IR, 10 shift DR, 11 run-idle.
- `cmd_len`  in  LEN_W  bit count (shift) or idle pulse count.
- `cmd_data`  in  MAX_LEN  TDI data, bit 0 shifted first.
- `rsp_valid`  out  1  one-cycle pulse at command completion.
- `rsp_data`  out  MAX_LEN  captured TDO, first captured bit in bit 0; held until next rsp.
- `busy`  out  1  = ~cmd_ready.
- `jtck_o`, `jtms_o`, `jtdi_o`, `jtrst_o`  out  1 each  JTAG pins to target (`jtrst_o` active-low).
- `jtdo_i`  in  1  target TDO.

## Operation
- States: INIT, IDLE, LOW (jtck_o=0 phase), HIGH (jtck_o=1 phase), DONE.
- `trst`=0: jtck_o=0, jtms_o=1, jtdi_o=0, jtrst_o=0, cmd_ready=0, rsp_valid=0, rsp_data=0, state INIT. Reset mid-command aborts it; no rsp_valid.
- `trst` released: jtrst_o=1 next cycle; INIT emits 6 JTAG bits TMS=1,1,1,1,1,0 (lands in Run-Test/Idle), then IDLE, cmd_ready=1. No rsp_valid for INIT.
- Every command starts and ends in Run-Test/Idle. TMS sequences per JTAG bit:
  - reset: 1,1,1,1,1,0 (6 bits).
  - IR: 1,1,0,0, then L shift bits with TMS=0 except last TMS=1, then 1,0 (L+6 bits).
  - DR: 1,0,0, then L shift bits (last TMS=1), then 1,0 (L+5 bits).
  - idle: L bits TMS=0.
- L = cmd_len; 0 treated as 1; >MAX_LEN clamped to MAX_LEN.
- jtdi_o = cmd_data[i] during shift bit i, 0 on all non-shift bits.
- TDO captured only during the L shift bits; rsp_data[i] = bit captured in shift bit i, bits ≥L zero. reset/idle return rsp_data=0.
- cmd_valid while busy ignored; cmd fields latched at acceptance, may change afterwards.

## Timing
- Accept at edge t: from t+1, jtms_o/jtdi_o carry bit 0, jtck_o=0 for CLK_DIV cycles, then jtck_o=1 for CLK_DIV cycles; next bit's TMS/TDI change at the same edge jtck_o falls.
- jtdo_i sampled on the `tck` edge where jtck_o rises (target updates TDO on falling TCK).
- N-bit command: at t+1+2·CLK_DIV·N jtck_o=0, rsp_valid=1, rsp_data valid, cmd_ready=1; back-to-back accept possible that cycle.
- INIT: cmd_ready=1 at 1+12·CLK_DIV cycles after first edge with trst=1.
- jtms_o=1 and jtck_o=0 while IDLE.

## Test plan
- Reset release, CLK_DIV=2: 6 jtck pulses TMS 1,1,1,1,1,0, jtrst_o=1 one cycle after release, cmd_ready=1 at cycle 25, no rsp_valid.
- IR L=4 data 0xA, TAP model capture-IR 0b0101: TMS 1,1,0,0,0,0,0,1,1,0; TDI on shift bits 0,1,0,1; rsp_valid 41 cycles after accept, rsp_data=0x5.
- DR L=32 data 0xDEADBEEF, model DR preloaded 0x12345678: 37 pulses, rsp_data=0x12345678, model DR=0xDEADBEEF after Update-DR.
- Idle L=3 then idle L=0: 3 pulses then 1 pulse, all TMS=0, rsp_data=0 both times.
- cmd_len=40 DR: clamped to 32 (37 pulses); cmd_valid pulsed while busy: ignored, exactly one rsp_valid.
- trst=0 mid DR shift: next cycle all outputs at reset values, no rsp_valid, INIT sequence reruns after release.
